// File: rtl/mac_sequencer_pkg.sv
// Shared constants and FSM state type for the nibble dot-product sequencer.
package mac_seq_pkg;

    localparam int NIB_W = 4;
    localparam int LANES = 4;
    localparam int ACC_W = 10;  // 4 * 15 * 15 = 900 fits in 10 bits

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        CALC,
        CMP,
        DONE
    } mac_seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Host-side handshake bundle for mac_sequencer.
// MAC_SEQ_SCORE_OUT_EN adds the per-vector score/score_valid outputs.
interface mac_sequencer_if #(
    parameter int NIB_W = mac_seq_pkg::NIB_W,
    parameter int ACC_W = mac_seq_pkg::ACC_W
);
    logic             start;
    logic [3:0]       vec_count;
    logic             in_valid;
    logic [NIB_W-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] best_val;
    logic [3:0]       best_idx;
`ifdef MAC_SEQ_SCORE_OUT_EN
    logic [ACC_W-1:0] score;
    logic             score_valid;

    modport master (
        output start, vec_count, in_valid, in_data,
        input  in_ready, busy, done, best_val, best_idx, score, score_valid
    );
    modport slave (
        input  start, vec_count, in_valid, in_data,
        output in_ready, busy, done, best_val, best_idx, score, score_valid
    );
`else
    modport master (
        output start, vec_count, in_valid, in_data,
        input  in_ready, busy, done, best_val, best_idx
    );
    modport slave (
        input  start, vec_count, in_valid, in_data,
        output in_ready, busy, done, best_val, best_idx
    );
`endif
endinterface

// File: rtl/mac_sequencer_dot4_unit.sv
// Combinational LANES-way unsigned multiply-add of packed weight and input vectors.
module dot4_unit #(
    parameter int NIB_W = mac_seq_pkg::NIB_W,
    parameter int LANES = mac_seq_pkg::LANES,
    parameter int ACC_W = mac_seq_pkg::ACC_W
) (
    input  logic [LANES*NIB_W-1:0] weights,
    input  logic [LANES*NIB_W-1:0] inputs,
    output logic [ACC_W-1:0]       sum
);

    logic [2*NIB_W-1:0] prod;

    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = (2*NIB_W)'(weights[i*NIB_W +: NIB_W]) * (2*NIB_W)'(inputs[i*NIB_W +: NIB_W]);
            sum  = sum + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Batch sequencer: loads one weight vector, streams up to 16 input vectors, tracks best score.
// MAC_SEQ_SCORE_OUT_EN exposes every vector's score with a one-cycle score_valid in CMP.
module mac_sequencer #(
    parameter int NIB_W = mac_seq_pkg::NIB_W,
    parameter int LANES = mac_seq_pkg::LANES,
    parameter int ACC_W = mac_seq_pkg::ACC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_sequencer_if.slave bus
);
    import mac_seq_pkg::*;

    localparam int VEC_W = LANES * NIB_W;
    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] NIB_LAST = CNT_W'(LANES - 1);

    mac_seq_state_t   state_q, state_d;
    logic [VEC_W-1:0] w_q, x_q;
    logic [CNT_W-1:0] nib_cnt_q;
    logic [3:0]       vec_idx_q, vec_last_q, best_idx_q;
    logic [ACC_W-1:0] score_q, best_val_q, dot_sum;
    logic             accept, nib_last, vec_final;

    assign accept    = bus.in_valid && bus.in_ready;
    assign nib_last  = (nib_cnt_q == NIB_LAST);
    assign vec_final = (vec_idx_q == vec_last_q);

    dot4_unit #(.NIB_W(NIB_W), .LANES(LANES), .ACC_W(ACC_W)) u_dot (
        .weights (w_q),
        .inputs  (x_q),
        .sum     (dot_sum)
    );

    // NOTE: reset is sampled on the clock edge only; sequential state always uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch can form.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_d = LOAD_W;
            end
            LOAD_W: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && nib_last) state_d = LOAD_X;
            end
            LOAD_X: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && nib_last) state_d = CALC;
            end
            CALC:    state_d = CMP;
            CMP:     state_d = vec_final ? DONE : LOAD_X;
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Nibbles enter at the top so the first one of a vector lands in lane 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q        <= '0;
            x_q        <= '0;
            nib_cnt_q  <= '0;
            vec_idx_q  <= '0;
            vec_last_q <= '0;
            score_q    <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    vec_last_q <= bus.vec_count;
                    best_val_q <= '0;
                    best_idx_q <= '0;
                    vec_idx_q  <= '0;
                    nib_cnt_q  <= '0;
                end
                LOAD_W: if (accept) begin
                    w_q       <= {bus.in_data, w_q[VEC_W-1:NIB_W]};
                    nib_cnt_q <= nib_last ? '0 : nib_cnt_q + CNT_W'(1);
                end
                LOAD_X: if (accept) begin
                    x_q       <= {bus.in_data, x_q[VEC_W-1:NIB_W]};
                    nib_cnt_q <= nib_last ? '0 : nib_cnt_q + CNT_W'(1);
                end
                CALC: score_q <= dot_sum;
                CMP: begin
                    // Strict compare keeps the earliest index on a tie.
                    if (score_q > best_val_q) begin
                        best_val_q <= score_q;
                        best_idx_q <= vec_idx_q;
                    end
                    if (!vec_final) vec_idx_q <= vec_idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.best_val = best_val_q;
    assign bus.best_idx = best_idx_q;

`ifdef MAC_SEQ_SCORE_OUT_EN
    assign bus.score       = score_q;
    assign bus.score_valid = (state_q == CMP);
`endif

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequencer for the 4-lane nibble dot-product datapath. It loads one weight vector, then streams up to 16 input vectors through the dot-product unit over a valid/ready nibble interface. It tracks the highest score and the index of the vector that produced it. It sits between the host pin interface and the dot-product datapath, and raises a one-cycle `done` when a batch is finished.

## Interface
Parameters:
- `NIB_W`, default 4: width of each weight/input element.
- `LANES`, default 4: number of elements per vector.
- `ACC_W`, default 10: score width. 4·15·15 = 900 < 1024.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; **synchronous, active-low; clock clk**
- `start`  in  1  begins a batch; sampled only in IDLE
- `vec_count`  in  4  number of input vectors minus 1 (1..16 vectors); latched on start
- `in_valid`  in  1  nibble available
- `in_data`  in  NIB_W  nibble payload
- `in_ready`  out  1  sequencer accepts a nibble this cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at batch end
- `best_val`  out  ACC_W  highest score in the batch
- `best_idx`  out  4  index of the vector that produced `best_val`

## Operation
- A nibble transfers on a rising edge where `in_valid && in_ready`. `in_ready` is high only in LOAD_W and LOAD_X.
- Nibbles enter a LANES×NIB_W shift register at the top and shift down. The first nibble of a vector ends in bits [3:0] (lane 0).
- FSM states and transitions:
  - IDLE: on `start`, latch `vec_count`, clear `best_val`, `best_idx`, the vector index and the nibble counter, then go to LOAD_W.
  - LOAD_W: accept LANES nibbles into the weight register, then go to LOAD_X.
  - LOAD_X: accept LANES nibbles into the input register, then go to CALC.
  - CALC: register `score_q` = Σ in[i]·w[i]. Products are unsigned, 8 bits each; the sum is ACC_W bits with no overflow possible.
  - CMP: if `score_q > best_val`, update `best_val` and `best_idx`. If the index equals the latched count, go to DONE. Otherwise increment the index and go to LOAD_X.
  - DONE: assert `done`, then go to IDLE.
- The comparison is strict. On a tie, the earlier index is kept. A batch where every score is zero returns `best_val=0`, `best_idx=0`.
- Weights are held for the whole batch. Only the input register reloads per vector.
- `start` outside IDLE is ignored. `start` in IDLE does not accept a nibble in the same cycle.
- `best_val` and `best_idx` hold their values after DONE until the next accepted `start`.
- `in_valid` gaps stall the FSM in its LOAD state. The nibble counter is preserved across gaps.

## Timing
- Reset values: `in_ready=0`, `busy=0`, `done=0`, `best_val=0`, `best_idx=0`. State is IDLE and all shift registers are zero.
- `rst_n` low at any edge, including mid-batch, returns to IDLE with the values above. A partially loaded vector is discarded. There is no `done` pulse.
- Latency: counting the edge that accepts the final nibble of the last vector as E, CALC runs in cycle E+1, CMP in E+2, and `done=1` in E+3. `best_*` are final in that same cycle.
- Per-vector overhead is 2 cycles (CALC, CMP) with no `in_ready`.
- Minimum batch of 1 vector with continuous `in_valid`: `start` edge, then 8 nibble cycles, then CALC, CMP, DONE.

## Configuration
- `MAC_SEQ_SCORE_OUT_EN` defined:
  - Adds output ports `score` (ACC_W) and `score_valid` (1).
  - `score_valid` pulses for one cycle in CMP, with `score = score_q` for every vector, in index order.
  - Both reset to 0.
- Not defined: the ports are absent and only the best value and index are reported. FSM timing is identical in both builds.

## Structure
- Package `mac_seq_pkg` holds:
  - Constants: `NIB_W`, `LANES`, `ACC_W`.
  - State enum `mac_seq_state_t`: IDLE, LOAD_W, LOAD_X, CALC, CMP, DONE.
- Sub-module `dot4_unit`: a purely combinational LANES-way unsigned multiply-add, (weights, inputs) → ACC_W sum. It is instantiated once.
- FSM, shift registers and best tracking live in `mac_sequencer`.

## Test plan
- Weights 1,1,1,1 with `vec_count=2`, vectors {1,2,3,4}, {15,15,15,15}, {2,2,2,2} → `best_val=60`, `best_idx=1`, one `done` pulse 3 cycles after the last nibble.
- Weights all 15 and input all 15 with `vec_count=0` → `best_val=900`, `best_idx=0`. Checks full width with no overflow.
- Tie: weights 1,0,0,0, inputs {5,…} and {5,…} → `best_idx=0`. Inputs {5,…} then {6,…} → `best_idx=1`, `best_val=6`.
- Back-pressure: `in_valid` toggling every other cycle → same results as with continuous valid. `in_ready` is never high in IDLE, CALC, CMP or DONE.
- `rst_n` low during the second vector's LOAD_X → next cycle shows IDLE, all outputs 0, no `done`. A fresh batch afterwards completes correctly.
- With `MAC_SEQ_SCORE_OUT_EN`, rerun the first scenario → `score_valid` pulses 3 times with `score` 10, 60, 8.
